ara_inval_queue: RTL

ARA_INVAL_QUEUE -- requirements
Module: ara_inval_queue

---
 rtl/ara_inval_queue.sv | 81 ++++++++
 1 files changed

// File: rtl/ara_inval_queue.sv
// Invalidation queue between the AXI invalidation filter and the CVA6 D-cache.
// Line-aligns addresses, merges back-to-back repeats and counts merged/discarded requests.
module ara_inval_queue #(
   parameter int unsigned AddrWidth   = 64,
   parameter int unsigned L1LineWidth = 16,
   parameter int unsigned Depth       = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       en_i,
   input  logic [AddrWidth-1:0]       inval_addr_i,
   input  logic                       inval_valid_i,
   output logic                       inval_ready_o,
   output logic [AddrWidth-1:0]       inval_addr_o,
   output logic                       inval_valid_o,
   input  logic                       inval_ready_i,
   output logic [$clog2(Depth):0]     count_o,
   output logic [15:0]                coalesced_o
);

   localparam int unsigned OffW = $clog2(L1LineWidth);
   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

   logic [AddrWidth-1:0] mem_q [Depth];
   logic [PtrW-1:0]      head_q, head_d, tail_q, tail_d;
   logic [CntW-1:0]      count_q, count_d;
   logic [15:0]          coal_q, coal_d;
   logic [AddrWidth-1:0] last_q, last_d;
   logic [AddrWidth-1:0] addr_al;
   logic                 full, deq, enq, hit, ready;

   always_comb begin
      addr_al = inval_addr_i;
      addr_al[OffW-1:0] = '0;
      full = (count_q == FullCnt);
      deq  = (count_q != '0) && inval_ready_i;
      // The last enqueued entry is always at the tail; it only leaves the queue
      // this cycle if it is also the head and is being dequeued.
      hit  = en_i && inval_valid_i && (count_q != '0) && (addr_al == last_q) &&
             !((count_q == CntW'(1)) && deq);
      ready = !en_i || hit || !full;
      enq  = en_i && inval_valid_i && !hit && !full;

      head_d  = head_q + PtrW'(deq);
      tail_d  = tail_q + PtrW'(enq);
      count_d = count_q + CntW'(enq) - CntW'(deq);
      last_d  = enq ? addr_al : last_q;
      coal_d  = coal_q;
      if (inval_valid_i && (!en_i || hit) && (coal_q != 16'hFFFF)) coal_d = coal_q + 16'd1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         coal_q  <= '0;
         last_q  <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         coal_q  <= coal_d;
         last_q  <= last_d;
      end
   end

   // Storage needs no reset; validity is carried by count_q.
   always_ff @(posedge clk_i) begin
      if (enq) mem_q[tail_q] <= addr_al;
   end

   assign inval_ready_o = ready;
   assign inval_addr_o  = mem_q[head_q];
   assign inval_valid_o = (count_q != '0);
   assign count_o       = count_q;
   assign coalesced_o   = coal_q;

endmodule
